// File: rtl/baby_alu_pkg.sv
// Shared definitions for the Manchester Baby ALU blocks: mode encoding,
// serial FSM states and the default datapath width.
package baby_alu_pkg;
  localparam int   DEF_WIDTH = 32;
  localparam logic MODE_SUB  = 1'b0;
  localparam logic MODE_NEG  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } serial_state_t;
endpackage

// File: rtl/serial_sub_digit.sv
// One DIGIT-bit slice of the serial subtractor: d = a - b - bin, with the
// outgoing borrow taken as the inverted top bit of a DIGIT+1-bit subtract.
module serial_sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);
  logic [DIGIT:0] diff;

  always_comb begin
    // The preset top bit survives only when no borrow leaves the slice
    diff = {1'b1, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
    d    = diff[DIGIT-1:0];
    bout = ~diff[DIGIT];
  end
endmodule

// File: rtl/baby_serial_subtractor.sv
// Multi-cycle A - B - borrow_in (or 0 - B - borrow_in) processed DIGIT bits
// per cycle, LSB first, with start/done handshake and zero/negative flags.
module baby_serial_subtractor
  import baby_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             borrow_in,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             zero,
  output logic             negative
);
  localparam int                N     = WIDTH / DIGIT;
  localparam int                CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("baby_serial_subtractor: DIGIT must divide WIDTH");
    end
  endgenerate

  serial_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             br_q, br_d, bout_q, bout_d;

  logic [DIGIT-1:0]       dig_d;
  logic                   dig_bout;
  logic [WIDTH+DIGIT-1:0] sh_cat;
  logic [WIDTH-1:0]       sh_next;

  serial_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .bin  (br_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  // New digit enters at the top so the LSB digit ends up at bit 0 after N shifts
  assign sh_cat  = {dig_d, sh_q};
  assign sh_next = sh_cat[WIDTH+DIGIT-1:DIGIT];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    br_d     = br_q;
    sh_d     = sh_q;
    result_d = result_q;
    bout_d   = bout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = (mode == MODE_NEG) ? '0 : data_a;
          b_d     = data_b;
          br_d    = borrow_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        br_d  = dig_bout;
        sh_d  = sh_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          result_d = sh_next;
          bout_d   = dig_bout;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      sh_q     <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      br_q     <= br_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      bout_q   <= bout_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign result     = result_q;
  assign borrow_out = bout_q;
  assign zero       = (result_q == '0);
  assign negative   = result_q[WIDTH-1];
endmodule

// File: tb/tb_baby_serial_subtractor.sv
// Bench for baby_serial_subtractor: four instances (DIGIT 1/4/8/32) checked
// against a scoreboard of expected results filled as each request is driven.
module tb_baby_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0, borrow_in = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic [3:0]  st = '0;
  logic [3:0]  done_v, busy_v, bo_v, z_v, n_v;
  logic [31:0] res_v [4];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int DG = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
      baby_serial_subtractor #(.WIDTH(32), .DIGIT(DG)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (st[g]),
        .mode       (mode),
        .borrow_in  (borrow_in),
        .data_a     (data_a),
        .data_b     (data_b),
        .busy       (busy_v[g]),
        .done       (done_v[g]),
        .result     (res_v[g]),
        .borrow_out (bo_v[g]),
        .zero       (z_v[g]),
        .negative   (n_v[g])
      );
    end
  endgenerate

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        bo;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic int dig_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : (i == 2) ? 8 : 32;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int i, input logic m, input logic [31:0] a,
                          input logic [31:0] b, input logic bin);
    logic [32:0] full;
    exp_t        e;
    full  = {1'b0, (m ? 32'h0 : a)} - {1'b0, b} - {32'h0, bin};
    e.idx = i;
    e.res = full[31:0];
    e.bo  = full[32];
    sbq.push_back(e);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i]) begin
        chk("busy_with_done", 64'(busy_v[i]), 64'(0));
        chk("sb_nonempty", 64'(sbq.size() != 0), 64'(1));
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_instance", 64'(i), 64'(e.idx));
          chk("sb_result", 64'(res_v[i]), 64'(e.res));
          chk("sb_borrow", 64'(bo_v[i]), 64'(e.bo));
          chk("sb_zero", 64'(z_v[i]), 64'(e.res == 32'h0));
          chk("sb_negative", 64'(n_v[i]), 64'(e.res[31]));
        end
      end
    end
  end

  task automatic chk_reset_vals(input int i, input string tag);
    chk({tag, "_busy"}, 64'(busy_v[i]), 64'(0));
    chk({tag, "_done"}, 64'(done_v[i]), 64'(0));
    chk({tag, "_result"}, 64'(res_v[i]), 64'(0));
    chk({tag, "_borrow"}, 64'(bo_v[i]), 64'(0));
    chk({tag, "_zero"}, 64'(z_v[i]), 64'(1));
    chk({tag, "_neg"}, 64'(n_v[i]), 64'(0));
  endtask

  // Drive one request, scramble operands after acceptance, wait for done
  task automatic run_op(input int i, input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic bin);
    int n, cyc, nb;
    n = 32 / dig_of(i);
    @(negedge clk);
    mode = m; data_a = a; data_b = b; borrow_in = bin; st[i] = 1'b1;
    push_exp(i, m, a, b, bin);
    @(posedge clk);
    #1;
    st[i] = 1'b0;
    data_a = $urandom; data_b = $urandom;
    mode = 1'($urandom); borrow_in = 1'($urandom);
    cyc = 0; nb = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy_v[i]) nb++;
    end while (!done_v[i] && cyc < n + 10);
    chk("latency", 64'(cyc), 64'(n + 1));
    chk("busy_cycles", 64'(nb), 64'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_reset_vals(i, "rst_init");
    rst_n = 1'b1;

    // Basic SUB
    run_op(0, 1'b0, 32'h0000_0005, 32'h0000_0003, 1'b0);
    chk("basic_result", 64'(res_v[0]), 64'h2);
    chk("basic_borrow", 64'(bo_v[0]), 64'(0));
    chk("basic_zero", 64'(z_v[0]), 64'(0));
    chk("basic_neg", 64'(n_v[0]), 64'(0));

    // NEG of zero
    run_op(0, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("neg0_result", 64'(res_v[0]), 64'h0);
    chk("neg0_zero", 64'(z_v[0]), 64'(1));
    chk("neg0_borrow", 64'(bo_v[0]), 64'(0));

    // Underflow with borrow-in
    run_op(0, 1'b0, 32'h0, 32'h1, 1'b1);
    chk("uflow_result", 64'(res_v[0]), 64'hFFFF_FFFE);
    chk("uflow_borrow", 64'(bo_v[0]), 64'(1));
    chk("uflow_neg", 64'(n_v[0]), 64'(1));

    // Reset during RUN cycle 10: aborted operation must never report
    @(negedge clk);
    mode = 1'b0; data_a = 32'h1234_5678; data_b = 32'h1; borrow_in = 1'b0; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_before_rst", 64'(busy_v[0]), 64'(1));
    #1 rst_n = 1'b0;
    #1 chk_reset_vals(0, "rst_mid");
    repeat (4) @(negedge clk);
    chk_reset_vals(0, "rst_hold");
    rst_n = 1'b1;
    run_op(0, 1'b0, 32'd100, 32'd58, 1'b0);
    chk("post_rst_result", 64'(res_v[0]), 64'd42);

    // NEG of 7
    run_op(0, 1'b1, 32'hDEAD_BEEF, 32'h7, 1'b0);
    chk("neg7_result", 64'(res_v[0]), 64'hFFFF_FFF9);

    // Back-to-back on DIGIT=8, with a start pulse during RUN that must be ignored
    @(negedge clk);
    mode = 1'b0; data_a = 32'h100; data_b = 32'h1; borrow_in = 1'b0; st[2] = 1'b1;
    push_exp(2, 1'b0, 32'h100, 32'h1, 1'b0);
    @(posedge clk);
    #1 st[2] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      st[2] = (cyc == 2);
    end while (!done_v[2] && cyc < 20);
    chk("b2b_first_latency", 64'(cyc), 64'(5));
    mode = 1'b0; data_a = 32'h10; data_b = 32'h10; borrow_in = 1'b0; st[2] = 1'b1;
    push_exp(2, 1'b0, 32'h10, 32'h10, 1'b0);
    @(posedge clk);
    #1 st[2] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_v[2] && cyc < 20);
    chk("b2b_second_gap", 64'(cyc), 64'(5));
    chk("b2b_result", 64'(res_v[2]), 64'h0);
    chk("b2b_zero", 64'(z_v[2]), 64'(1));
    repeat (8) @(negedge clk);

    // Randomised sweep over DIGIT 1, 4, 32
    for (int c = 0; c < 3; c++) begin
      int i;
      i = (c == 2) ? 3 : c;
      for (int k = 0; k < 1000; k++)
        run_op(i, 1'($urandom), $urandom, $urandom, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
